// File: rtl/ysyx_22050243_imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
//   state_t : responder FSM states
//   err_t   : response error codes carried on rsp_err
//   NOP     : instruction returned alongside any error (addi x0, x0, 0)
package ysyx_22050243_imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } err_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/ysyx_22050243_imem_resp_if.sv
// Fetch request/response channel between the core fetch stage and the
// instruction-memory responder.
//   req_valid/req_ready/req_addr : byte-PC request handshake
//   rsp_valid/rsp_ready          : response handshake
//   rsp_inst/rsp_err             : instruction word and error code
// master = fetch stage, slave = responder.
interface ysyx_22050243_imem_resp_if;

  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic [1:0]  rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );

endinterface

// File: rtl/ysyx_22050243_imem_array.sv
// DEPTH x 32 instruction store. Synchronous write port used by the preload
// path, asynchronous read port sampled by the responder when it enters RESP.
// Kept as its own module so it can be replaced by an SRAM macro wrapper.
//   clk      : write clock
//   wr_en    : write strobe
//   wr_idx   : write word index
//   wr_data  : write word
//   rd_idx   : read word index
//   rd_data  : read word
module ysyx_22050243_imem_array #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // A write on the same edge as the responder's capture is not seen by it:
  // the register samples this value before the write lands.
  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ysyx_22050243_imem_resp.sv
// Instruction-memory responder. Accepts fetch requests, waits LATENCY
// cycles, then presents the instruction word (or NOP plus an error code for
// misaligned / out-of-range PCs) until the fetch stage takes it.
//   clk, rst_n            : clock, async active-low reset
//   bus (slave)           : request/response channel
//   flush                 : core redirect, drops any in-flight request
//   ld_en/ld_idx/ld_data  : preload write port into the store
//   rsp_cnt               : completed response handshakes (wrapping)
module ysyx_22050243_imem_resp
  import ysyx_22050243_imem_pkg::*;
#(
  parameter  logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter  int          DEPTH     = 1024,
  parameter  int          LATENCY   = 1,
  localparam int          AW        = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_22050243_imem_resp_if.slave  bus,
  input  logic                      flush,
  input  logic                      ld_en,
  input  logic [AW-1:0]             ld_idx,
  input  logic [31:0]               ld_data,
  output logic [31:0]               rsp_cnt
);

  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [63:0] SPAN     = 64'(DEPTH) * 64'd4;

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [63:0]   addr_q;
  logic          accept, hs, load_rsp;
  logic [63:0]   lk_addr, lk_off;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_data;
  logic [31:0]   lk_inst;
  logic [1:0]    lk_err;

  assign bus.req_ready = !flush && ((state == IDLE) || ((state == RESP) && bus.rsp_ready));
  assign bus.rsp_valid = (state == RESP);
  assign accept        = bus.req_valid && bus.req_ready;
  assign hs            = (state == RESP) && bus.rsp_ready;

  // With LATENCY = 1 RESP is entered on the accept edge itself, so the
  // lookup must use the incoming address; from WAIT it uses the latched one.
  assign lk_addr = (state == WAIT) ? addr_q : bus.req_addr;
  assign lk_off  = lk_addr - BASE_ADDR;
  assign rd_idx  = lk_off[AW+1:2];

  ysyx_22050243_imem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .wr_en   (ld_en),
    .wr_idx  (ld_idx),
    .wr_data (ld_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // Addresses below BASE_ADDR wrap to huge offsets and fail the same check.
  always_comb begin
    lk_err  = ERR_OK;
    lk_inst = rd_data;
    if (lk_addr[1:0] != 2'b00) begin
      lk_err  = ERR_MISALIGN;
      lk_inst = NOP;
    end else if (lk_off >= SPAN) begin
      lk_err  = ERR_RANGE;
      lk_inst = NOP;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load_rsp = 1'b0;
    if (flush) begin
      state_nx = IDLE;
      cnt_nx   = 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state_nx = RESP;
              load_rsp = 1'b1;
            end else begin
              state_nx = WAIT;
              cnt_nx   = CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state_nx = RESP;
            load_rsp = 1'b1;
          end else begin
            cnt_nx = cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            if (accept) begin
              if (LATENCY == 1) begin
                state_nx = RESP;
                load_rsp = 1'b1;
              end else begin
                state_nx = WAIT;
                cnt_nx   = CNT_INIT;
              end
            end else begin
              state_nx = IDLE;
            end
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= 64'd0;
      bus.rsp_inst <= 32'd0;
      bus.rsp_err  <= 2'd0;
      rsp_cnt      <= 32'd0;
    end else begin
      if (accept) addr_q <= bus.req_addr;
      if (load_rsp) begin
        bus.rsp_inst <= lk_inst;
        bus.rsp_err  <= lk_err;
      end
      if (hs) rsp_cnt <= rsp_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_imem_resp.sv
// Bench for the instruction-memory responder: three instances at
// LATENCY 1, 3 and 4 share clock, reset and the preload port.
module tb_ysyx_22050243_imem_resp;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid_d, rsp_ready_d, flush_d;
  logic [63:0] req_addr_d [3];
  logic [2:0]  req_ready_o, rsp_valid_o;
  logic [31:0] rsp_inst_o [3];
  logic [1:0]  rsp_err_o [3];
  logic [31:0] rsp_cnt_o [3];
  logic        ld_en;
  logic [9:0]  ld_idx;
  logic [31:0] ld_data;

  logic [31:0] mdl_mem [DEPTH];
  int unsigned cnt_m [3];
  int          passed, total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ysyx_22050243_imem_resp_if bus ();
    assign bus.req_valid = req_valid_d[g];
    assign bus.req_addr  = req_addr_d[g];
    assign bus.rsp_ready = rsp_ready_d[g];
    assign req_ready_o[g] = bus.req_ready;
    assign rsp_valid_o[g] = bus.rsp_valid;
    assign rsp_inst_o[g]  = bus.rsp_inst;
    assign rsp_err_o[g]   = bus.rsp_err;

    ysyx_22050243_imem_resp #(
      .BASE_ADDR (BASE),
      .DEPTH     (DEPTH),
      .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .flush   (flush_d[g]),
      .ld_en   (ld_en),
      .ld_idx  (ld_idx),
      .ld_data (ld_data),
      .rsp_cnt (rsp_cnt_o[g])
    );
  end

  function automatic int lat(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  // Reference: {err, inst} straight from the addressing rules.
  function automatic logic [33:0] ref_rsp(input logic [63:0] a);
    logic [63:0] w;
    if (a % 4 != 0) return {2'd1, NOP_W};
    if (a < BASE || a >= BASE + 64'(DEPTH) * 4) return {2'd2, NOP_W};
    w = (a - BASE) / 4;
    return {2'd0, mdl_mem[w[9:0]]};
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    case ($urandom_range(0, 9))
      0:       a = BASE + 64'($urandom_range(0, DEPTH - 1)) * 4 + 64'($urandom_range(1, 3));
      1:       a = BASE + 64'(DEPTH) * 4 + 64'($urandom_range(0, 255)) * 4;
      2:       a = BASE - 64'($urandom_range(1, 256)) * 4;
      default: a = BASE + 64'($urandom_range(0, DEPTH - 1)) * 4;
    endcase
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One request with rsp_ready held high; checks latency, data, count.
  task automatic single(input int d, input logic [63:0] a, input string tag);
    logic [33:0] e;
    int k;
    e = ref_rsp(a);
    req_valid_d[d] = 1'b1;
    req_addr_d[d]  = a;
    rsp_ready_d[d] = 1'b1;
    #1;
    chk({tag, "_req_ready"}, 64'(req_ready_o[d]), 64'd1);
    tick();
    req_valid_d[d] = 1'b0;
    k = 0;
    while (!rsp_valid_o[d] && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(lat(d) - 1));
    chk({tag, "_inst"}, 64'(rsp_inst_o[d]), 64'(e[31:0]));
    chk({tag, "_err"}, 64'(rsp_err_o[d]), 64'(e[33:32]));
    tick();
    cnt_m[d]++;
    chk({tag, "_valid_drop"}, 64'(rsp_valid_o[d]), 64'd0);
    chk({tag, "_cnt"}, 64'(rsp_cnt_o[d]), 64'(cnt_m[d]));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [33:0] e;
    logic [31:0] old_w, new_w;
    logic        acc, hsk;
    int          k, issued, got, cyc;
    logic [33:0] q [$];
    logic [33:0] ex;

    passed = 0;
    total  = 0;
    rst_n = 1'b0;
    req_valid_d = '0;
    rsp_ready_d = '0;
    flush_d     = '0;
    for (int d = 0; d < 3; d++) begin
      req_addr_d[d] = '0;
      cnt_m[d] = 0;
    end
    ld_en = 1'b0;
    ld_idx = '0;
    ld_data = '0;

    // Reset values
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", 64'(rsp_valid_o[d]), 64'd0);
      chk("rst_inst",  64'(rsp_inst_o[d]),  64'd0);
      chk("rst_err",   64'(rsp_err_o[d]),   64'd0);
      chk("rst_cnt",   64'(rsp_cnt_o[d]),   64'd0);
    end
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) chk("rst_req_ready", 64'(req_ready_o[d]), 64'd1);

    // Preload the whole store
    for (int i = 0; i < DEPTH; i++) begin
      ld_en   = 1'b1;
      ld_idx  = 10'(i);
      ld_data = (i == 0) ? 32'h0010_0093 : $urandom;
      mdl_mem[i] = ld_data;
      tick();
    end
    ld_en = 1'b0;

    // Basic and error responses on the LATENCY=1 instance
    single(0, BASE, "l1_word0");
    chk("l1_word0_value", 64'(rsp_inst_o[0]), 64'h0010_0093);
    single(0, BASE + 64'd2, "misalign");
    single(0, BASE + 64'(DEPTH) * 4, "above_range");
    single(0, 64'h7FFF_FFFC, "below_range");
    single(0, BASE + 64'(DEPTH) * 4 - 4, "last_word");

    // Stall on the LATENCY=3 instance
    e = ref_rsp(BASE + 64'd40);
    req_valid_d[1] = 1'b1;
    req_addr_d[1]  = BASE + 64'd40;
    rsp_ready_d[1] = 1'b0;
    tick();
    req_valid_d[1] = 1'b0;
    k = 0;
    while (!rsp_valid_o[1] && k < 20) begin
      chk("stall_wait_ready", 64'(req_ready_o[1]), 64'd0);
      tick();
      k++;
    end
    chk("stall_latency", 64'(k), 64'd2);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(rsp_valid_o[1]), 64'd1);
      chk("stall_inst",  64'(rsp_inst_o[1]),  64'(e[31:0]));
      chk("stall_ready", 64'(req_ready_o[1]), 64'd0);
      tick();
    end
    rsp_ready_d[1] = 1'b1;
    #1;
    chk("stall_release_ready", 64'(req_ready_o[1]), 64'd1);
    tick();
    cnt_m[1]++;
    chk("stall_done_valid", 64'(rsp_valid_o[1]), 64'd0);
    chk("stall_done_cnt", 64'(rsp_cnt_o[1]), 64'(cnt_m[1]));

    // Back-to-back on LATENCY=1
    req_valid_d[0] = 1'b1;
    rsp_ready_d[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr_d[0] = BASE + 64'(i) * 4;
      tick();
      chk("b2b_valid", 64'(rsp_valid_o[0]), 64'd1);
      chk("b2b_inst",  64'(rsp_inst_o[0]),  64'(mdl_mem[i]));
    end
    req_valid_d[0] = 1'b0;
    tick();
    cnt_m[0] += 3;
    chk("b2b_idle", 64'(rsp_valid_o[0]), 64'd0);
    chk("b2b_cnt", 64'(rsp_cnt_o[0]), 64'(cnt_m[0]));

    // Flush while waiting on LATENCY=4
    req_valid_d[2] = 1'b1;
    req_addr_d[2]  = BASE + 64'd12;
    rsp_ready_d[2] = 1'b1;
    tick();
    req_valid_d[2] = 1'b0;
    flush_d[2] = 1'b1;
    #1;
    chk("flush_ready", 64'(req_ready_o[2]), 64'd0);
    tick();
    flush_d[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("flush_no_valid", 64'(rsp_valid_o[2]), 64'd0);
      tick();
    end
    chk("flush_cnt", 64'(rsp_cnt_o[2]), 64'(cnt_m[2]));
    single(2, BASE + 64'd8, "after_flush");

    // Flush coinciding with a response handshake still counts it
    req_valid_d[0] = 1'b1;
    req_addr_d[0]  = BASE + 64'd20;
    rsp_ready_d[0] = 1'b0;
    tick();
    flush_d[0] = 1'b1;
    rsp_ready_d[0] = 1'b1;
    req_addr_d[0] = BASE + 64'd24;
    #1;
    chk("flush_hs_ready", 64'(req_ready_o[0]), 64'd0);
    tick();
    flush_d[0] = 1'b0;
    req_valid_d[0] = 1'b0;
    cnt_m[0]++;
    chk("flush_hs_idle", 64'(rsp_valid_o[0]), 64'd0);
    chk("flush_hs_cnt", 64'(rsp_cnt_o[0]), 64'(cnt_m[0]));

    // Preload on the capture edge returns the old word
    old_w = mdl_mem[4];
    new_w = ~old_w;
    req_valid_d[0] = 1'b1;
    req_addr_d[0]  = BASE + 64'd16;
    rsp_ready_d[0] = 1'b0;
    ld_en = 1'b1;
    ld_idx = 10'd4;
    ld_data = new_w;
    tick();
    ld_en = 1'b0;
    req_valid_d[0] = 1'b0;
    mdl_mem[4] = new_w;
    chk("ld_same_edge_inst", 64'(rsp_inst_o[0]), 64'(old_w));
    rsp_ready_d[0] = 1'b1;
    tick();
    cnt_m[0]++;
    single(0, BASE + 64'd16, "ld_new_word");

    // Randomized traffic with stalls, one instance at a time
    for (int d = 0; d < 3; d++) begin
      q.delete();
      issued = 0;
      got = 0;
      cyc = 0;
      req_valid_d[d] = 1'b1;
      req_addr_d[d] = rand_addr();
      while (got < 30 && cyc < 3000) begin
        rsp_ready_d[d] = ($urandom_range(0, 3) != 0);
        #1;
        hsk = rsp_valid_o[d] && rsp_ready_d[d];
        acc = req_valid_d[d] && req_ready_o[d];
        if (hsk) begin
          chk("rnd_expected_pending", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            ex = q.pop_front();
            chk("rnd_inst", 64'(rsp_inst_o[d]), 64'(ex[31:0]));
            chk("rnd_err", 64'(rsp_err_o[d]), 64'(ex[33:32]));
          end
          got++;
          cnt_m[d]++;
        end
        if (acc) begin
          q.push_back(ref_rsp(req_addr_d[d]));
          issued++;
        end
        tick();
        if (acc) begin
          if (issued == 30) req_valid_d[d] = 1'b0;
          else req_addr_d[d] = rand_addr();
        end
        cyc++;
      end
      req_valid_d[d] = 1'b0;
      rsp_ready_d[d] = 1'b1;
      chk("rnd_all_responses", 64'(got), 64'd30);
      chk("rnd_cnt", 64'(rsp_cnt_o[d]), 64'(cnt_m[d]));
    end

    // Asynchronous reset while a response is held
    req_valid_d[1] = 1'b1;
    req_addr_d[1]  = BASE;
    rsp_ready_d[1] = 1'b0;
    tick();
    req_valid_d[1] = 1'b0;
    k = 0;
    while (!rsp_valid_o[1] && k < 20) begin
      tick();
      k++;
    end
    chk("arst_in_resp", 64'(rsp_valid_o[1]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(rsp_valid_o[1]), 64'd0);
    chk("arst_cnt", 64'(rsp_cnt_o[1]), 64'd0);
    chk("arst_inst", 64'(rsp_inst_o[1]), 64'd0);
    chk("arst_ready", 64'(req_ready_o[1]), 64'd1);
    #3;
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) cnt_m[d] = 0;
    rsp_ready_d = '0;
    tick();
    single(0, BASE + 64'd4, "after_reset_mem_kept");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
